wshb_mire: RTL and testbench

Wishbone master that continuously writes a grid test pattern (mire) into the SDRAM framebuffer, one 32-bit pixel per transfer, scanning the frame in raster order. It drives the mire slave port of the Wishbone interconnect, which arbitrates it against the VGA reader toward the SDRAM controller. Writes are issued in bursts of at most BURST transfers. After each burst, cyc drops for one cycle so the interconnect can hand the bus to the VGA reader.

---
 rtl/wshb_mire_pkg.sv | 18 +
 rtl/wshb_if.sv | 28 ++
 rtl/mire_scan_ctr.sv | 50 +++++
 rtl/wshb_mire.sv | 94 +++++++++
 tb/tb_wshb_mire.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/wshb_mire_pkg.sv
// Shared types and constants for the mire (grid test pattern) Wishbone writer.
package wshb_mire_pkg;

   typedef enum logic [0:0] {
      GAP   = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [31:0] COLOR_WHITE = 32'h00FFFFFF;
   localparam logic [31:0] COLOR_BLACK = 32'h00000000;
   localparam logic [2:0]  CTI_CLASSIC = 3'b000;

   // Counter width for a 0..n-1 range; never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle (32-bit data, byte address) shared by masters and slaves.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      input  clk, rst, ack, err, rty, dat_sm,
      output cyc, stb, we, adr, dat_ms, sel, cti, bte
   );

   modport slave (
      input  clk, rst, cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output ack, err, rty, dat_sm
   );
endinterface

// File: rtl/mire_scan_ctr.sv
// Raster scan counters: x/y position plus a linear pixel index kept in step
// with them so the framebuffer address needs no multiplier.
module mire_scan_ctr
   import wshb_mire_pkg::*;
#(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   localparam int XW = cw(HDISP),
   localparam int YW = cw(VDISP),
   localparam int PW = cw(HDISP * VDISP)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          adv,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [PW-1:0] pix,
   output logic          line_last,
   output logic          frame_last
);

   localparam logic [XW-1:0] XMAX = XW'(HDISP - 1);
   localparam logic [YW-1:0] YMAX = YW'(VDISP - 1);

   assign line_last  = (x == XMAX);
   assign frame_last = line_last && (y == YMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x   <= '0;
         y   <= '0;
         pix <= '0;
      end else if (adv) begin
         if (frame_last) begin
            x   <= '0;
            y   <= '0;
            pix <= '0;
         end else begin
            pix <= pix + PW'(1);
            if (line_last) begin
               x <= '0;
               y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/wshb_mire.sv
// Wishbone master writing a white grid on black into the framebuffer, in bursts
// separated by a one-cycle cyc drop so the interconnect can serve the VGA reader.
module wshb_mire
   import wshb_mire_pkg::*;
#(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int BURST = 64,
   parameter int GRID  = 16
) (
   input  logic  clk,
   input  logic  rst_n,
   wshb_if.master wshb_ifm,
   output logic  frame_done
);

   localparam int XW = cw(HDISP);
   localparam int YW = cw(VDISP);
   localparam int PW = cw(HDISP * VDISP);
   localparam int BW = cw(BURST);

   localparam logic [BW-1:0] BMAX  = BW'(BURST - 1);
   localparam logic [31:0]   GMASK = 32'(GRID - 1);
   localparam logic [31:0]   XLAST = 32'(HDISP - 1);
   localparam logic [31:0]   YLAST = 32'(VDISP - 1);

   state_t        state;
   logic [BW-1:0] bcnt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [PW-1:0] pix;
   logic          line_last;
   logic          frame_last;
   logic          adv;

   // Grid lines every GRID pixels plus a closing border on the last row/column.
   function automatic logic [31:0] mire_color(input logic [31:0] xe, input logic [31:0] ye);
      if (((xe & GMASK) == 32'd0) || ((ye & GMASK) == 32'd0) || (xe == XLAST) || (ye == YLAST))
         return COLOR_WHITE;
      return COLOR_BLACK;
   endfunction

   // err skips the pixel like ack; rty (or nothing) simply re-presents it.
   assign adv = (state == WRITE) && (wshb_ifm.ack || wshb_ifm.err);

   mire_scan_ctr #(
      .HDISP (HDISP),
      .VDISP (VDISP)
   ) u_scan (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .x          (x),
      .y          (y),
      .pix        (pix),
      .line_last  (line_last),
      .frame_last (frame_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= GAP;
         bcnt       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= adv && frame_last;
         case (state)
            GAP: state <= WRITE;
            WRITE: begin
               if (adv) begin
                  if (bcnt == BMAX) begin
                     bcnt  <= '0;
                     state <= GAP;
                  end else begin
                     bcnt <= bcnt + BW'(1);
                  end
               end
            end
            default: state <= GAP;
         endcase
      end
   end

   // Address and data derive only from registered counters, so they hold during waits.
   assign wshb_ifm.cyc    = (state == WRITE);
   assign wshb_ifm.stb    = (state == WRITE);
   assign wshb_ifm.we     = 1'b1;
   assign wshb_ifm.sel    = 4'hF;
   assign wshb_ifm.cti    = CTI_CLASSIC;
   assign wshb_ifm.bte    = 2'b00;
   assign wshb_ifm.adr    = 32'({pix, 2'b00});
   assign wshb_ifm.dat_ms = mire_color(32'(x), 32'(y));

endmodule

// File: tb/tb_wshb_mire.sv
// Scoreboard bench for wshb_mire on an 8x4 frame, grid pitch 4, bursts of 4.
module tb_wshb_mire;
   import wshb_mire_pkg::*;

   localparam int HD = 8;
   localparam int VD = 4;
   localparam int BU = 4;
   localparam int GR = 4;
   localparam int NPIX = HD * VD;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic        last;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_done;
   int   total = 0;
   int   bad = 0;
   rec_t q[$];
   // Hand-derived map, bit = y*8+x: rows 0 and 3 all white, rows 1/2 white at x=0,4,7.
   logic [31:0] white_map = 32'hFF9191FF;

   always #5 clk = ~clk;

   wshb_if bus (.clk(clk), .rst(~rst_n));

   wshb_mire #(
      .HDISP (HD),
      .VDISP (VD),
      .BURST (BU),
      .GRID  (GR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wshb_ifm   (bus.master),
      .frame_done (frame_done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   task automatic push_pix(input int p);
      rec_t r;
      r.adr  = 32'(p * 4);
      r.dat  = white_map[p] ? 32'h00FFFFFF : 32'h00000000;
      r.last = (p == NPIX - 1);
      q.push_back(r);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_timeout: got %0d pending want 0", nm, q.size());
         q.delete();
      end
   endtask

   // Monitor: pops on every completed transfer, and tracks cyc gaps and frame_done.
   initial begin
      logic        exp_cyc, fd_next, prev_stall, done;
      logic [31:0] prev_adr, prev_dat;
      int          bcount;
      rec_t        r;
      exp_cyc = 1'b1; fd_next = 1'b0; prev_stall = 1'b0;
      prev_adr = '0; prev_dat = '0; bcount = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_cyc", 32'(bus.cyc), 32'd0);
            chk("rst_stb", 32'(bus.stb), 32'd0);
            chk("rst_frame_done", 32'(frame_done), 32'd0);
            exp_cyc = 1'b1; fd_next = 1'b0; prev_stall = 1'b0; bcount = 0;
         end else begin
            chk("cyc", 32'(bus.cyc), 32'(exp_cyc));
            chk("stb", 32'(bus.stb), 32'(exp_cyc));
            chk("frame_done", 32'(frame_done), 32'(fd_next));
            if (prev_stall && bus.stb) begin
               chk("hold_adr", bus.adr, prev_adr);
               chk("hold_dat", bus.dat_ms, prev_dat);
            end
            done = bus.cyc && bus.stb && (bus.ack || bus.err);
            fd_next = 1'b0;
            exp_cyc = 1'b1;
            if (done) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_write: got adr %h want none", bus.adr);
               end else begin
                  r = q.pop_front();
                  chk("adr", bus.adr, r.adr);
                  chk("dat", bus.dat_ms, r.dat);
                  fd_next = r.last;
               end
               bcount++;
               if (bcount == BU) begin
                  bcount = 0;
                  exp_cyc = 1'b0;
               end
            end
            prev_stall = bus.cyc && bus.stb && !(bus.ack || bus.err);
            prev_adr = bus.adr;
            prev_dat = bus.dat_ms;
         end
      end
   end

   initial begin
      bus.ack = 1'b0; bus.err = 1'b0; bus.rty = 1'b0; bus.dat_sm = '0;

      // Reset, then ack held high: two bursts with a one-cycle gap between.
      repeat (3) @(negedge clk);
      for (int p = 0; p < 8; p++) push_pix(p);
      bus.ack = 1'b1;
      #2 rst_n = 1'b1;
      #1;
      chk("first_cyc_before_edge1", 32'(bus.cyc), 32'd0);
      chk("reset_adr", bus.adr, 32'h0);
      @(posedge clk);
      #1;
      chk("first_stb_at_edge2", 32'(bus.stb), 32'd1);
      drain("burst");
      bus.ack = 1'b0;

      // Advance one more pixel, then reset while stalled at adr 0x24.
      push_pix(8);
      bus.ack = 1'b1;
      drain("pre_reset");
      bus.ack = 1'b0;
      @(negedge clk);
      chk("stalled_adr", bus.adr, 32'h24);
      #1 rst_n = 1'b0;
      #1;
      chk("async_cyc_drop", 32'(bus.cyc), 32'd0);
      chk("async_stb_drop", 32'(bus.stb), 32'd0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // Restart from pixel 0, then withhold ack for 5 cycles at adr 0x8.
      push_pix(0);
      push_pix(1);
      bus.ack = 1'b1;
      drain("restart");
      bus.ack = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("wait_cyc", 32'(bus.cyc), 32'd1);
         chk("wait_adr", bus.adr, 32'h8);
         chk("wait_dat", bus.dat_ms, 32'h00FFFFFF);
      end
      @(posedge clk);
      #1;
      push_pix(2);
      bus.ack = 1'b1;
      drain("after_wait");
      bus.ack = 1'b0;

      // Retry twice on adr 0xC, then ack.
      bus.rty = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rty_adr", bus.adr, 32'hC);
      end
      @(posedge clk);
      #1;
      bus.rty = 1'b0;
      push_pix(3);
      bus.ack = 1'b1;
      drain("after_rty");
      bus.ack = 1'b0;

      // err advances like ack; ack wins over a simultaneous rty.
      push_pix(4);
      push_pix(5);
      bus.err = 1'b1;
      drain("err");
      bus.err = 1'b0;
      push_pix(6);
      bus.ack = 1'b1;
      bus.rty = 1'b1;
      drain("ack_rty");
      bus.ack = 1'b0;
      bus.rty = 1'b0;

      // Rest of the frame and wrap into the next one.
      for (int p = 7; p < NPIX; p++) push_pix(p);
      for (int p = 0; p < 4; p++) push_pix(p);
      bus.ack = 1'b1;
      drain("frame");
      bus.ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("after_wrap_adr", bus.adr, 32'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
